// File: rtl/rotate_tracker.sv
// ---------------------------------------------------------------------------
// rotate_tracker
//   Receive-side monitor for the one-hot rotating pattern produced by the
//   rotator. The incoming pattern is compared each cycle against the last
//   accepted one. Every legal one-position move becomes a step pulse with a
//   direction and a position. Cycles between steps are measured, a stall is
//   flagged after TIMEOUT idle cycles, and illegal patterns or jumps set a
//   sticky error.
//
//   Optional feature macro: ROT_REVERSAL_ERR_EN
//     defined   : after the first step, a step against the current direction
//                 is treated as an illegal move.
//     undefined : reversals are legal steps and dir follows them.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   pat       in   [WIDTH-1:0] one-hot pattern from the rotator
//   clr       in   synchronous pulse: clear err/stall, restart acquisition
//   locked    out  tracking a valid pattern
//   step      out  1-cycle pulse per legal one-position move
//   dir       out  direction of last step (1 = toward MSB)
//   pos       out  [$clog2(WIDTH)-1:0] index of the set bit of accepted pattern
//   step_cnt  out  [STEP_W-1:0] steps since lock, wrapping
//   interval  out  [CNT_W-1:0] cycles between the two most recent steps
//   stall     out  no step for TIMEOUT cycles while tracking
//   err       out  sticky illegal pattern / illegal move flag
// ---------------------------------------------------------------------------
module rotate_tracker #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 15,
  parameter int TIMEOUT = 25000,
  parameter int STEP_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         pat,
  input  logic                     clr,
  output logic                     locked,
  output logic                     step,
  output logic                     dir,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic [STEP_W-1:0]        step_cnt,
  output logic [CNT_W-1:0]         interval,
  output logic                     stall,
  output logic                     err
);

  localparam int PW = $clog2(WIDTH);

  localparam logic [WIDTH-1:0]  PAT_ZERO   = WIDTH'(0);
  localparam logic [WIDTH-1:0]  PAT_ONE    = WIDTH'(1);
  localparam logic [PW-1:0]     POS_ZERO   = PW'(0);
  localparam logic [PW-1:0]     POS_ONE    = PW'(1);
  localparam logic [PW-1:0]     POS_MAX    = PW'(WIDTH - 1);
  localparam logic [STEP_W-1:0] STEP_ZERO  = STEP_W'(0);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]    CNT_INC    = (CNT_W + 1)'(1);
  localparam logic [CNT_W:0]    TIMEOUT_V  = (CNT_W + 1)'(TIMEOUT);

`ifdef ROT_REVERSAL_ERR_EN
  localparam logic REV_ERR_EN = 1'b1;
`else
  localparam logic REV_ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_TRACK   = 2'd1,
    ST_ERROR   = 2'd2
  } state_t;

  // x has exactly one bit set: non-zero and clearing the lowest set bit leaves zero
  function automatic logic is_onehot(input logic [WIDTH-1:0] x);
    return (x != PAT_ZERO) && ((x & (x - PAT_ONE)) == PAT_ZERO);
  endfunction

  function automatic logic [WIDTH-1:0] rol(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x);
    return {x[0], x[WIDTH-1:1]};
  endfunction

  // Only meaningful for a one-hot argument; OR-ing indices avoids a priority chain
  function automatic logic [PW-1:0] onehot_index(input logic [WIDTH-1:0] x);
    logic [PW-1:0] idx;
    idx = POS_ZERO;
    for (int i = 0; i < WIDTH; i++) begin
      idx = idx | (x[i] ? PW'(i) : POS_ZERO);
    end
    return idx;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [WIDTH-1:0]  pat_q_r, pat_q_nxt_s;
  logic [CNT_W-1:0]  idle_r, idle_nxt_s;
  logic              locked_r, locked_nxt_s;
  logic              step_r, step_nxt_s;
  logic              dir_r, dir_nxt_s;
  logic [PW-1:0]     pos_r, pos_nxt_s;
  logic [STEP_W-1:0] step_cnt_r, step_cnt_nxt_s;
  logic [CNT_W-1:0]  interval_r, interval_nxt_s;
  logic              stall_r, stall_nxt_s;
  logic              err_r, err_nxt_s;
  logic              moved_r, moved_nxt_s;   // at least one step since lock
  logic [CNT_W:0]    idle_inc_s;             // idle+1 with a carry bit
  logic [CNT_W-1:0]  idle_sat_s;             // idle+1 saturated to CNT_W bits
  logic              rev_left_s, rev_right_s;
  logic              go_left_s, go_right_s;

  assign idle_inc_s  = {1'b0, idle_r} + CNT_INC;
  assign idle_sat_s  = idle_inc_s[CNT_W] ? CNT_MAX : idle_inc_s[CNT_W-1:0];
  // A move against the established direction, only once a first step has set it
  assign rev_left_s  = REV_ERR_EN & moved_r & ~dir_r;
  assign rev_right_s = REV_ERR_EN & moved_r & dir_r;
  assign go_left_s   = (pat == rol(pat_q_r)) & ~rev_left_s;
  assign go_right_s  = (pat == ror(pat_q_r)) & ~rev_right_s;

  // Next-state and next-output decode; clr overrides pattern decode
  always_comb begin
    state_nxt_s    = state_r;
    pat_q_nxt_s    = pat_q_r;
    idle_nxt_s     = idle_r;
    locked_nxt_s   = locked_r;
    step_nxt_s     = 1'b0;
    dir_nxt_s      = dir_r;
    pos_nxt_s      = pos_r;
    step_cnt_nxt_s = step_cnt_r;
    interval_nxt_s = interval_r;
    stall_nxt_s    = stall_r;
    err_nxt_s      = err_r;
    moved_nxt_s    = moved_r;
    if (clr) begin
      err_nxt_s    = 1'b0;
      stall_nxt_s  = 1'b0;
      locked_nxt_s = 1'b0;
      state_nxt_s  = ST_ACQUIRE;
    end else begin
      case (state_r)
        ST_ACQUIRE: begin
          if (is_onehot(pat)) begin
            pat_q_nxt_s    = pat;
            pos_nxt_s      = onehot_index(pat);
            locked_nxt_s   = 1'b1;
            step_cnt_nxt_s = STEP_ZERO;
            idle_nxt_s     = CNT_ZERO;
            moved_nxt_s    = 1'b0;
            state_nxt_s    = ST_TRACK;
          end else begin
            state_nxt_s    = ST_ACQUIRE;
          end
        end
        ST_TRACK: begin
          if (pat == pat_q_r) begin
            idle_nxt_s = idle_sat_s;
            if (idle_inc_s >= TIMEOUT_V) begin
              stall_nxt_s = 1'b1;
            end else begin
              stall_nxt_s = stall_r;
            end
          end else if (go_left_s || go_right_s) begin
            step_nxt_s     = 1'b1;
            dir_nxt_s      = go_left_s;
            if (go_left_s) begin
              pos_nxt_s = (pos_r == POS_MAX) ? POS_ZERO : pos_r + POS_ONE;
            end else begin
              pos_nxt_s = (pos_r == POS_ZERO) ? POS_MAX : pos_r - POS_ONE;
            end
            pat_q_nxt_s    = pat;
            step_cnt_nxt_s = step_cnt_r + STEP_ONE;
            interval_nxt_s = idle_sat_s;
            idle_nxt_s     = CNT_ZERO;
            stall_nxt_s    = 1'b0;
            moved_nxt_s    = 1'b1;
          end else begin
            err_nxt_s      = 1'b1;
            locked_nxt_s   = 1'b0;
            state_nxt_s    = ST_ERROR;
          end
        end
        ST_ERROR: begin
          err_nxt_s    = 1'b1;
          locked_nxt_s = 1'b0;
          state_nxt_s  = ST_ERROR;
        end
        default: begin
          locked_nxt_s = 1'b0;
          state_nxt_s  = ST_ACQUIRE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_ACQUIRE;
      pat_q_r    <= PAT_ZERO;
      idle_r     <= CNT_ZERO;
      locked_r   <= 1'b0;
      step_r     <= 1'b0;
      dir_r      <= 1'b0;
      pos_r      <= POS_ZERO;
      step_cnt_r <= STEP_ZERO;
      interval_r <= CNT_ZERO;
      stall_r    <= 1'b0;
      err_r      <= 1'b0;
      moved_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pat_q_r    <= pat_q_nxt_s;
      idle_r     <= idle_nxt_s;
      locked_r   <= locked_nxt_s;
      step_r     <= step_nxt_s;
      dir_r      <= dir_nxt_s;
      pos_r      <= pos_nxt_s;
      step_cnt_r <= step_cnt_nxt_s;
      interval_r <= interval_nxt_s;
      stall_r    <= stall_nxt_s;
      err_r      <= err_nxt_s;
      moved_r    <= moved_nxt_s;
    end
  end

  assign locked   = locked_r;
  assign step     = step_r;
  assign dir      = dir_r;
  assign pos      = pos_r;
  assign step_cnt = step_cnt_r;
  assign interval = interval_r;
  assign stall    = stall_r;
  assign err      = err_r;

endmodule

// File: tb/tb_rotate_tracker.sv
// ---------------------------------------------------------------------------
// tb_rotate_tracker
//   Directed self-checking bench for rotate_tracker (WIDTH=4, CNT_W=5,
//   TIMEOUT=20 so stall and interval saturation are reachable quickly).
//   Honours ROT_REVERSAL_ERR_EN for the reversal expectations.
// ---------------------------------------------------------------------------
module tb_rotate_tracker;

  logic        clk;
  logic        rst_n;
  logic [3:0]  pat;
  logic        clr;
  logic        locked;
  logic        step;
  logic        dir;
  logic [1:0]  pos;
  logic [15:0] step_cnt;
  logic [4:0]  interval;
  logic        stall;
  logic        err;

  int checks_cnt = 0;
  int errors_cnt = 0;

  rotate_tracker #(
    .WIDTH   (4),
    .CNT_W   (5),
    .TIMEOUT (20),
    .STEP_W  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pat      (pat),
    .clr      (clr),
    .locked   (locked),
    .step     (step),
    .dir      (dir),
    .pos      (pos),
    .step_cnt (step_cnt),
    .interval (interval),
    .stall    (stall),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clear, then lock on pattern p
  task automatic relock(input logic [3:0] p);
    clr = 1'b1;
    pat = p;
    tick();
    clr = 1'b0;
    tick();
  endtask

  logic [3:0] seq [4];
  logic [1:0] seq_pos [4];

  initial begin
    seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;
    seq_pos[0] = 2'd1; seq_pos[1] = 2'd2; seq_pos[2] = 2'd3; seq_pos[3] = 2'd0;

    // 1: reset, then lock on 0001
    rst_n = 1'b0;
    clr   = 1'b0;
    pat   = 4'b0001;
    tick();
    tick();
    check_val("rst_locked",   32'(locked),   32'd0);
    check_val("rst_step",     32'(step),     32'd0);
    check_val("rst_pos",      32'(pos),      32'd0);
    check_val("rst_err",      32'(err),      32'd0);
    check_val("rst_stall",    32'(stall),    32'd0);
    check_val("rst_step_cnt", 32'(step_cnt), 32'd0);
    check_val("rst_interval", 32'(interval), 32'd0);
    rst_n = 1'b1;
    tick();
    check_val("lock_locked", 32'(locked), 32'd1);
    check_val("lock_pos",    32'(pos),    32'd0);
    check_val("lock_step",   32'(step),   32'd0);

    // 2: four left steps, each pattern held 10 cycles
    for (int k = 0; k < 4; k++) begin
      pat = seq[k];
      tick();
      check_val("walk_step",     32'(step),     32'd1);
      check_val("walk_dir",      32'(dir),      32'd1);
      check_val("walk_pos",      32'(pos),      32'(seq_pos[k]));
      check_val("walk_step_cnt", 32'(step_cnt), 32'(k + 1));
      if (k > 0) begin
        check_val("walk_interval", 32'(interval), 32'd10);
      end
      tick();
      check_val("walk_pulse_end", 32'(step), 32'd0);
      for (int h = 0; h < 8; h++) begin
        tick();
      end
    end
    check_val("walk_total", 32'(step_cnt), 32'd4);

    // 3: right step with wrap 0001 -> 1000
    relock(4'b0001);
    check_val("r_lock_cnt", 32'(step_cnt), 32'd0);
    pat = 4'b1000;
    tick();
    check_val("r_step",     32'(step),     32'd1);
    check_val("r_dir",      32'(dir),      32'd0);
    check_val("r_pos",      32'(pos),      32'd3);
    check_val("r_step_cnt", 32'(step_cnt), 32'd1);

    // 4: jump is illegal; clr recovers and relocks once pattern is one-hot
    relock(4'b0001);
    pat = 4'b0100;
    tick();
    check_val("jump_err",    32'(err),    32'd1);
    check_val("jump_locked", 32'(locked), 32'd0);
    check_val("jump_step",   32'(step),   32'd0);
    check_val("jump_pos",    32'(pos),    32'd0);
    pat = 4'b0110;
    tick();
    check_val("err_sticky", 32'(err), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_val("clr_err",    32'(err),    32'd0);
    check_val("clr_locked", 32'(locked), 32'd0);
    tick();
    check_val("acq_ignore_locked", 32'(locked), 32'd0);
    check_val("acq_ignore_err",    32'(err),    32'd0);
    pat = 4'b0100;
    tick();
    check_val("relock_locked", 32'(locked), 32'd1);
    check_val("relock_pos",    32'(pos),    32'd2);
    check_val("relock_err",    32'(err),    32'd0);

    // 5: stall after 20 idle cycles, interval saturates at 31
    relock(4'b0010);
    for (int h = 0; h < 19; h++) begin
      tick();
    end
    check_val("stall_pre", 32'(stall), 32'd0);
    tick();
    check_val("stall_set", 32'(stall), 32'd1);
    for (int h = 0; h < 20; h++) begin
      tick();
    end
    check_val("stall_hold", 32'(stall), 32'd1);
    pat = 4'b0100;
    tick();
    check_val("stall_step",     32'(step),     32'd1);
    check_val("stall_clear",    32'(stall),    32'd0);
    check_val("stall_interval", 32'(interval), 32'd31);
    check_val("stall_pos",      32'(pos),      32'd2);

    // 6: left, left, then right
    relock(4'b0001);
    pat = 4'b0010;
    tick();
    pat = 4'b0100;
    tick();
    check_val("rev_pre_dir", 32'(dir), 32'd1);
    pat = 4'b0010;
    tick();
`ifdef ROT_REVERSAL_ERR_EN
    check_val("rev_err",  32'(err),  32'd1);
    check_val("rev_step", 32'(step), 32'd0);
    check_val("rev_dir",  32'(dir),  32'd1);
    check_val("rev_pos",  32'(pos),  32'd2);
`else
    check_val("rev_err",  32'(err),  32'd0);
    check_val("rev_step", 32'(step), 32'd1);
    check_val("rev_dir",  32'(dir),  32'd0);
    check_val("rev_pos",  32'(pos),  32'd1);
`endif
    check_val("rev_pre_rst_cnt", 32'(step_cnt),
`ifdef ROT_REVERSAL_ERR_EN
              32'd2
`else
              32'd3
`endif
              );

    // Asynchronous reset mid-sequence, checked between clock edges
    rst_n = 1'b0;
    #2;
    check_val("arst_locked",   32'(locked),   32'd0);
    check_val("arst_step_cnt", 32'(step_cnt), 32'd0);
    check_val("arst_pos",      32'(pos),      32'd0);
    check_val("arst_interval", 32'(interval), 32'd0);
    check_val("arst_err",      32'(err),      32'd0);
    check_val("arst_dir",      32'(dir),      32'd0);
    check_val("arst_step",     32'(step),     32'd0);
    rst_n = 1'b1;
    pat = 4'b1000;
    tick();
    check_val("arst_relock",     32'(locked), 32'd1);
    check_val("arst_relock_pos", 32'(pos),    32'd3);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
